// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling at BAUD_MULT clocks per bit.
// Latency: byte valid 9*BAUD_MULT+HALF+3 clocks after the line falls; no backpressure, one-cycle pulses.
module uart_rx #(
  parameter int BAUD_MULT = 139
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_data,
  output logic [7:0] o_byte_out,
  output logic       o_data_valid,
  output logic       o_rx_active,
  output logic       o_framing_err
);

  localparam int CW = $clog2(BAUD_MULT);
  localparam logic [CW-1:0] HALF = CW'((BAUD_MULT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(BAUD_MULT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  state_e          state_q;
  logic            meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            active_q;
  logic            ferr_q;

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= i_rx_data;
      rx_s_q <= meta_q;
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q  <= START;
            cnt_q    <= '0;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              // Line went back high before mid-start: treat as noise.
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) state_q <= STOP;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            if (rx_s_q) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Bad stop bit; wait for the line to recover so a break counts once.
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_out    = byte_q;
  assign o_data_valid  = valid_q;
  assign o_rx_active   = active_q;
  assign o_framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 16 clk/bit, one at 139 clk/bit.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx16;
  logic       rx139;
  logic [7:0] byte16, byte139;
  logic       vld16, vld139, act16, act139, err16, err139;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  int v16 = 0, e16 = 0, a16 = 0, vcyc16 = 0;
  int v139 = 0, e139 = 0;
  int both_hi = 0;
  logic [7:0] q16[$];
  logic [7:0] q139[$];

  uart_rx #(.BAUD_MULT(16)) dut16 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx16),
    .o_byte_out(byte16), .o_data_valid(vld16), .o_rx_active(act16), .o_framing_err(err16)
  );

  uart_rx #(.BAUD_MULT(139)) dut139 (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx139),
    .o_byte_out(byte139), .o_data_valid(vld139), .o_rx_active(act139), .o_framing_err(err139)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld16) begin v16++; q16.push_back(byte16); vcyc16 = cyc; end
    if (err16) e16++;
    if (act16) a16++;
    if (vld139) begin v139++; q139.push_back(byte139); end
    if (err139) e139++;
    if ((vld16 && err16) || (vld139 && err139)) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx139 = v;
    else     rx16  = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stopb, input int bl);
    drive(sel, 1'b0, bl);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bl);
    drive(sel, stopb, bl);
  endtask

  task automatic clr;
    v16 = 0; e16 = 0; a16 = 0; v139 = 0; e139 = 0;
    q16.delete(); q139.delete();
  endtask

  function automatic logic [7:0] pop16();
    logic [7:0] b;
    b = 8'hxx;
    if (q16.size() > 0) b = q16.pop_front();
    return b;
  endfunction

  initial begin
    int start_k;
    int lat;
    rst_n = 1'b0;
    rx16  = 1'b1;
    rx139 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_byte", byte16, 8'h00);
    check("rst_valid", vld16, 0);
    check("rst_active", act16, 0);
    check("rst_ferr", err16, 0);
    check("rst_byte139", byte139, 8'h00);
    rst_n = 1'b1;
    drive(0, 1'b1, 10);

    // 1: single frame, latency and active window
    clr();
    start_k = cyc;
    send(0, 8'hA5, 1'b1, 16);
    drive(0, 1'b1, 30);
    lat = vcyc16 - (start_k + 1);
    $display("info: 0xA5 latency %0d cycles", lat);
    check("t1_count", v16, 1);
    check("t1_byte", pop16(), 8'hA5);
    check("t1_ferr", e16, 0);
    check("t1_latency_window", (lat >= 152 && lat <= 156), 1);
    check("t1_active_cycles", a16, 152);

    // 2: back-to-back frames
    clr();
    send(0, 8'h00, 1'b1, 16);
    send(0, 8'hFF, 1'b1, 16);
    send(0, 8'h3C, 1'b1, 16);
    drive(0, 1'b1, 30);
    check("t2_count", v16, 3);
    check("t2_b0", pop16(), 8'h00);
    check("t2_b1", pop16(), 8'hFF);
    check("t2_b2", pop16(), 8'h3C);
    check("t2_ferr", e16, 0);

    // 3: short glitch
    clr();
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 40);
    check("t3_valid", v16, 0);
    check("t3_ferr", e16, 0);
    check("t3_active_bounded", (a16 > 0 && a16 <= 10), 1);
    check("t3_idle", act16, 0);
    check("t3_byte_hold", byte16, 8'h3C);

    // 4: bad stop bit followed by a break, then recovery
    clr();
    send(0, 8'h55, 1'b0, 16);
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 32);
    check("t4_ferr_once", e16, 1);
    check("t4_no_valid", v16, 0);
    check("t4_byte_hold", byte16, 8'h3C);
    send(0, 8'h12, 1'b1, 16);
    drive(0, 1'b1, 30);
    check("t4_count", v16, 1);
    check("t4_byte", pop16(), 8'h12);
    check("t4_ferr_after", e16, 1);

    // 5: reset in the middle of data bit 4
    clr();
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, logic'((8'hC3 >> i) & 8'h01), 16);
    drive(0, 1'b0, 8);
    rst_n = 1'b0;
    #2;
    check("t5_rst_byte", byte16, 8'h00);
    check("t5_rst_valid", vld16, 0);
    check("t5_rst_active", act16, 0);
    check("t5_rst_ferr", err16, 0);
    rx16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 40);
    check("t5_no_pulse", v16 + e16, 0);
    send(0, 8'h81, 1'b1, 16);
    drive(0, 1'b1, 30);
    check("t5_count", v16, 1);
    check("t5_byte", pop16(), 8'h81);

    // 6: +/-4% baud error at BAUD_MULT=139
    clr();
    send(1, 8'h5A, 1'b1, 133);
    drive(1, 1'b1, 300);
    check("t6_slow_count", v139, 1);
    check("t6_slow_byte", byte139, 8'h5A);
    clr();
    send(1, 8'h5A, 1'b1, 145);
    drive(1, 1'b1, 300);
    check("t6_fast_count", v139, 1);
    check("t6_fast_byte", byte139, 8'h5A);
    check("t6_ferr", e139, 0);

    check("valid_ferr_exclusive", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
